// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: sequencing FSM for a multi-cycle RV32I subset core
// (lw, sw, R-type add/sub/and/or/slt, beq) on a shared-ALU, single-memory
// datapath.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   instr           IR contents, valid from DECODE onward
//   EQ              ALU zero flag (branch compare)
//   mem_ready       memory finishes the current access this cycle
//   mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite   memory/datapath enables
//   ALUsrcA, ALUsrcB, ResultSrc, ImmSrc, ALUctrl            datapath selects
//   illegal         sticky illegal-instruction trap flag
//   retire_cnt      retired-instruction counter (wraps)
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             EQ,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUsrcA,
    output logic [1:0]       ALUsrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUctrl,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
        MEMWRITE, EXECR, ALUWB, BEQ, TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state, next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       rtype_ok;
    logic       retire;

    // Un-gated Moore/Mealy controls; reset gating happens at the ports.
    logic       req_s, adr_s, mw_s, irw_s, pcw_s, rw_s, ill_s;
    logic [1:0] srca_s, srcb_s, res_s, imm_s;
    logic [2:0] alu_s;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign rtype_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retire_cnt <= '0;
        else if (retire) retire_cnt <= retire_cnt + 1'b1;
    end

    always_comb begin
        next   = state;
        retire = 1'b0;
        req_s  = 1'b0;
        adr_s  = 1'b0;
        mw_s   = 1'b0;
        irw_s  = 1'b0;
        pcw_s  = 1'b0;
        rw_s   = 1'b0;
        ill_s  = 1'b0;
        srca_s = 2'b00;
        srcb_s = 2'b00;
        res_s  = 2'b00;
        imm_s  = 2'b00;
        alu_s  = ALU_ADD;
        case (state)
            FETCH: begin
                // PC+4 computed on the ALU and written straight back via ResultSrc=10
                req_s  = 1'b1;
                srcb_s = 2'b10;
                res_s  = 2'b10;
                irw_s  = mem_ready;
                pcw_s  = mem_ready;
                if (mem_ready) next = DECODE;
            end
            DECODE: begin
                // Speculative branch target OldPC+immB lands in ALUOut
                srca_s = 2'b01;
                srcb_s = 2'b01;
                imm_s  = 2'b10;
                case (opcode)
                    7'b0000011, 7'b0100011: next = MEMADR;
                    7'b0110011:             next = rtype_ok ? EXECR : TRAP;
                    7'b1100011:             next = BEQ;
                    default:                next = TRAP;
                endcase
            end
            MEMADR: begin
                srca_s = 2'b10;
                srcb_s = 2'b01;
                // instr[5] separates sw (0100011) from lw (0000011)
                imm_s  = instr[5] ? 2'b01 : 2'b00;
                next   = instr[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                req_s = 1'b1;
                adr_s = 1'b1;
                if (mem_ready) next = MEMWB;
            end
            MEMWB: begin
                res_s  = 2'b01;
                rw_s   = 1'b1;
                retire = 1'b1;
                next   = FETCH;
            end
            MEMWRITE: begin
                req_s = 1'b1;
                adr_s = 1'b1;
                mw_s  = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    next   = FETCH;
                end
            end
            EXECR: begin
                srca_s = 2'b10;
                case (funct3)
                    3'b000:  alu_s = instr[30] ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_s = ALU_SLT;
                    3'b110:  alu_s = ALU_OR;
                    3'b111:  alu_s = ALU_AND;
                    default: alu_s = ALU_ADD;
                endcase
                next = ALUWB;
            end
            ALUWB: begin
                rw_s   = 1'b1;
                retire = 1'b1;
                next   = FETCH;
            end
            BEQ: begin
                srca_s = 2'b10;
                alu_s  = ALU_SUB;
                pcw_s  = EQ;
                retire = 1'b1;
                next   = FETCH;
            end
            TRAP: begin
                ill_s = 1'b1;
                next  = TRAP;
            end
            default: next = FETCH;
        endcase
    end

    // While reset is held every control is forced low, even though the
    // state register already sits in FETCH.
    assign mem_req   = rst_n & req_s;
    assign AdrSrc    = rst_n & adr_s;
    assign MemWrite  = rst_n & mw_s;
    assign IRWrite   = rst_n & irw_s;
    assign PCWrite   = rst_n & pcw_s;
    assign RegWrite  = rst_n & rw_s;
    assign illegal   = rst_n & ill_s;
    assign ALUsrcA   = rst_n ? srca_s : 2'b00;
    assign ALUsrcB   = rst_n ? srcb_s : 2'b00;
    assign ResultSrc = rst_n ? res_s  : 2'b00;
    assign ImmSrc    = rst_n ? imm_s  : 2'b00;
    assign ALUctrl   = rst_n ? alu_s  : 3'b000;

endmodule
